// File: rtl/retire_stage_pkg.sv
// Shared definitions for the two-wide retire stage: sizes, opcode constants,
// FSM encoding and the destination-register decoder.
package retire_stage_pkg;

  localparam int PRF_IDX   = 6;
  localparam int ARCH_REGS = 32;
  localparam int AMT_IDX   = $clog2(ARCH_REGS);
  localparam int REC_IDX   = AMT_IDX - 1;

  typedef logic [PRF_IDX-1:0] preg_t;
  typedef logic [AMT_IDX-1:0] areg_t;
  typedef logic [REC_IDX-1:0] pair_t;

  // Opcodes whose destination lives in ir[4:0]
  localparam logic [5:0] OP_INTA = 6'h10;
  localparam logic [5:0] OP_INTL = 6'h11;
  localparam logic [5:0] OP_INTS = 6'h12;
  localparam logic [5:0] OP_INTM = 6'h13;
  localparam logic [5:0] OP_FPTI = 6'h1C;

  // Opcodes whose destination lives in ir[25:21]
  localparam logic [5:0] OP_LDA  = 6'h08;
  localparam logic [5:0] OP_LDAH = 6'h09;
  localparam logic [5:0] OP_LDF  = 6'h20;
  localparam logic [5:0] OP_LDG  = 6'h21;
  localparam logic [5:0] OP_LDS  = 6'h22;
  localparam logic [5:0] OP_LDT  = 6'h23;
  localparam logic [5:0] OP_LDL  = 6'h28;
  localparam logic [5:0] OP_LDQ  = 6'h29;
  localparam logic [5:0] OP_JSR  = 6'h1A;
  localparam logic [5:0] OP_BR   = 6'h30;
  localparam logic [5:0] OP_BSR  = 6'h34;

  localparam areg_t ZERO_REG = areg_t'(31);

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_RECOVER = 1'b1
  } rs_state_e;

  typedef struct packed {
    logic  valid;
    areg_t idx;
  } dest_t;

  function automatic dest_t dest_decode(input logic [31:0] ir);
    dest_t d;
    d.valid = 1'b0;
    d.idx   = ir[4:0];
    case (ir[31:26])
      OP_INTA, OP_INTL, OP_INTS, OP_INTM, OP_FPTI: begin
        d.valid = 1'b1;
        d.idx   = ir[4:0];
      end
      OP_LDA, OP_LDAH, OP_LDF, OP_LDG, OP_LDS, OP_LDT,
      OP_LDL, OP_LDQ, OP_JSR, OP_BR, OP_BSR: begin
        d.valid = 1'b1;
        d.idx   = ir[25:21];
      end
      default: d.valid = 1'b0;
    endcase
    // r31 reads as zero, so a write to it never needs a mapping
    if (d.idx == ZERO_REG) d.valid = 1'b0;
    return d;
  endfunction

endpackage

// File: rtl/retire_stage_if.sv
// Bundle between the ROB/front end and the retire stage. Every *_valid is a
// single-cycle qualifier with no ready/backpressure: a high valid at a clock edge is consumed at that edge.
interface retire_stage_if;
  import retire_stage_pkg::*;

  logic        dout1_valid;
  logic        dout2_valid;
  logic [31:0] ir_out1;
  logic [31:0] ir_out2;
  logic [63:0] npc_out1;
  logic [63:0] npc_out2;
  preg_t       pdest_out1;
  preg_t       pdest_out2;
  logic        branch_miss;
  logic [63:0] ba_out;

  logic        free1_valid;
  logic        free2_valid;
  preg_t       free1_preg;
  preg_t       free2_preg;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        rec_busy;
  logic        rec_valid;
  pair_t       rec_idx;
  preg_t       rec_preg_a;
  preg_t       rec_preg_b;
  logic [63:0] retired_cnt;
  rs_state_e   dbg_state;

  modport master (
    output dout1_valid, dout2_valid, ir_out1, ir_out2, npc_out1, npc_out2,
           pdest_out1, pdest_out2, branch_miss, ba_out,
    input  free1_valid, free2_valid, free1_preg, free2_preg, redirect_valid,
           redirect_pc, rec_busy, rec_valid, rec_idx, rec_preg_a, rec_preg_b,
           retired_cnt, dbg_state
  );

  modport slave (
    input  dout1_valid, dout2_valid, ir_out1, ir_out2, npc_out1, npc_out2,
           pdest_out1, pdest_out2, branch_miss, ba_out,
    output free1_valid, free2_valid, free1_preg, free2_preg, redirect_valid,
           redirect_pc, rec_busy, rec_valid, rec_idx, rec_preg_a, rec_preg_b,
           retired_cnt, dbg_state
  );

endinterface

// File: rtl/retire_stage_arch_map_table.sv
// Architectural map table: arch reg -> committed physical reg, two read/write
// ports (slot2 wins on a same-index write) and a pair read for recovery.
module arch_map_table
  import retire_stage_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  areg_t rd_addr1,
  input  areg_t rd_addr2,
  output preg_t rd_data1,
  output preg_t rd_data2,
  input  logic  wr_en1,
  input  areg_t wr_addr1,
  input  preg_t wr_data1,
  input  logic  wr_en2,
  input  areg_t wr_addr2,
  input  preg_t wr_data2,
  input  pair_t pair_idx,
  output preg_t pair_a,
  output preg_t pair_b
);

  preg_t regs [ARCH_REGS];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < ARCH_REGS; i++) regs[i] <= preg_t'(i);
    end else begin
      if (wr_en1) regs[wr_addr1] <= wr_data1;
      if (wr_en2) regs[wr_addr2] <= wr_data2;
    end
  end

  assign rd_data1 = regs[rd_addr1];
  assign rd_data2 = regs[rd_addr2];
  assign pair_a   = regs[{pair_idx, 1'b0}];
  assign pair_b   = regs[{pair_idx, 1'b1}];

endmodule

// File: rtl/retire_stage.sv
// Two-wide commit stage: updates the AMT, frees superseded physical registers
// and, on a mispredict, redirects fetch and streams the AMT to the front end.
module retire_stage
  import retire_stage_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  retire_stage_if.slave  bus
);

  rs_state_e state, state_nxt;
  pair_t     k, k_nxt;

  dest_t d1, d2;
  logic  s1, s2, we1, we2;
  preg_t amt_rd1, amt_rd2, pair_a, pair_b;
  pair_t pair_sel;

  logic        free1_valid_nxt, free2_valid_nxt;
  preg_t       free1_preg_nxt, free2_preg_nxt;
  logic        redirect_valid_nxt;
  logic [63:0] redirect_pc_nxt;
  logic        rec_busy_nxt, rec_valid_nxt;
  pair_t       rec_idx_nxt;
  preg_t       rec_preg_a_nxt, rec_preg_b_nxt;
  logic [63:0] retired_cnt_nxt;

  always_comb begin
    d1  = dest_decode(bus.ir_out1);
    d2  = dest_decode(bus.ir_out2);
    s1  = bus.dout1_valid && (state == ST_IDLE);
    s2  = s1 && bus.dout2_valid;
    we1 = s1 && d1.valid;
    we2 = s2 && d2.valid;
    // IDLE pre-reads pair 0 for the first beat; RECOVER looks one pair ahead
    pair_sel = (state == ST_IDLE) ? '0 : pair_t'(k + 1'b1);
  end

  arch_map_table u_amt (
    .clk      (clk),
    .reset    (reset),
    .rd_addr1 (d1.idx),
    .rd_addr2 (d2.idx),
    .rd_data1 (amt_rd1),
    .rd_data2 (amt_rd2),
    .wr_en1   (we1),
    .wr_addr1 (d1.idx),
    .wr_data1 (bus.pdest_out1),
    .wr_en2   (we2),
    .wr_addr2 (d2.idx),
    .wr_data2 (bus.pdest_out2),
    .pair_idx (pair_sel),
    .pair_a   (pair_a),
    .pair_b   (pair_b)
  );

  always_comb begin
    state_nxt          = state;
    k_nxt              = k;
    free1_valid_nxt    = 1'b0;
    free2_valid_nxt    = 1'b0;
    free1_preg_nxt     = '0;
    free2_preg_nxt     = '0;
    redirect_valid_nxt = 1'b0;
    redirect_pc_nxt    = bus.redirect_pc;
    rec_busy_nxt       = 1'b0;
    rec_valid_nxt      = 1'b0;
    rec_idx_nxt        = bus.rec_idx;
    rec_preg_a_nxt     = bus.rec_preg_a;
    rec_preg_b_nxt     = bus.rec_preg_b;
    retired_cnt_nxt    = bus.retired_cnt;

    case (state)
      ST_IDLE: begin
        free1_valid_nxt = we1;
        free2_valid_nxt = we2;
        if (we1) free1_preg_nxt = amt_rd1;
        // slot2 superseding slot1's fresh mapping frees slot1's pdest
        if (we2) free2_preg_nxt = (we1 && (d1.idx == d2.idx)) ? bus.pdest_out1 : amt_rd2;
        retired_cnt_nxt = bus.retired_cnt + 64'(s1) + 64'(s2);

        if (bus.branch_miss) begin
          state_nxt          = ST_RECOVER;
          k_nxt              = '0;
          redirect_valid_nxt = 1'b1;
          redirect_pc_nxt    = bus.ba_out;
          rec_busy_nxt       = 1'b1;
          rec_valid_nxt      = 1'b1;
          rec_idx_nxt        = '0;
          // beat 0 must reflect this cycle's commits, which the AMT has not yet absorbed
          rec_preg_a_nxt = pair_a;
          rec_preg_b_nxt = pair_b;
          if (we1 && (d1.idx == areg_t'(0))) rec_preg_a_nxt = bus.pdest_out1;
          if (we2 && (d2.idx == areg_t'(0))) rec_preg_a_nxt = bus.pdest_out2;
          if (we1 && (d1.idx == areg_t'(1))) rec_preg_b_nxt = bus.pdest_out1;
          if (we2 && (d2.idx == areg_t'(1))) rec_preg_b_nxt = bus.pdest_out2;
        end
      end

      ST_RECOVER: begin
        if (k == '1) begin
          state_nxt = ST_IDLE;
          k_nxt     = '0;
        end else begin
          k_nxt          = pair_t'(k + 1'b1);
          rec_busy_nxt   = 1'b1;
          rec_valid_nxt  = 1'b1;
          rec_idx_nxt    = pair_t'(k + 1'b1);
          rec_preg_a_nxt = pair_a;
          rec_preg_b_nxt = pair_b;
        end
      end

      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      k     <= '0;
    end else begin
      state <= state_nxt;
      k     <= k_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.free1_valid    <= 1'b0;
      bus.free2_valid    <= 1'b0;
      bus.free1_preg     <= '0;
      bus.free2_preg     <= '0;
      bus.redirect_valid <= 1'b0;
      bus.redirect_pc    <= '0;
      bus.rec_busy       <= 1'b0;
      bus.rec_valid      <= 1'b0;
      bus.rec_idx        <= '0;
      bus.rec_preg_a     <= '0;
      bus.rec_preg_b     <= '0;
      bus.retired_cnt    <= '0;
    end else begin
      bus.free1_valid    <= free1_valid_nxt;
      bus.free2_valid    <= free2_valid_nxt;
      bus.free1_preg     <= free1_preg_nxt;
      bus.free2_preg     <= free2_preg_nxt;
      bus.redirect_valid <= redirect_valid_nxt;
      bus.redirect_pc    <= redirect_pc_nxt;
      bus.rec_busy       <= rec_busy_nxt;
      bus.rec_valid      <= rec_valid_nxt;
      bus.rec_idx        <= rec_idx_nxt;
      bus.rec_preg_a     <= rec_preg_a_nxt;
      bus.rec_preg_b     <= rec_preg_b_nxt;
      bus.retired_cnt    <= retired_cnt_nxt;
    end
  end

  assign bus.dbg_state = state;

endmodule
